// File: rtl/pipe_pkg.sv
// Shared definitions for the valid/ready pipeline stage register.
// The state encoding doubles as the occupancy count.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [OCC_W-1:0] occupancy(input state_t s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Upstream/downstream handshake bundle for one pipeline stage register.
// A transfer happens on a rising edge where valid and ready are both high;
// valid may not depend on ready, and the stage only captures/retires then.
interface pipe_stage_skid_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/pipe_data_reg.sv
// N-bit data register: async active-low reset, synchronous clear, load enable.
// Clear wins over load so a squash never lets a bundle slip through.
module pipe_data_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with flush, hazard hold and an optional skid entry.
// With SKID=1 in_ready comes only from registered state plus hold/flush.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int N    = 32,
  parameter int SKID = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             hold,
  pipe_stage_skid_if.slave bus,
  output logic [OCC_W-1:0] count,
  output state_t           dbg_state
);

  localparam bit HAS_SKID = (SKID != 0);

  state_t       state;
  state_t       state_nx;
  logic [N-1:0] main_q;
  logic [N-1:0] main_d;
  logic [N-1:0] skid_q;
  logic         main_valid;
  logic         skid_valid;
  logic         accept;
  logic         pop;
  logic         load_main;
  logic         load_skid;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == FULL);

  generate
    if (HAS_SKID) begin : g_rdy_skid
      assign bus.in_ready = ~skid_valid & ~hold & ~flush & rst_n;
    end else begin : g_rdy_flow
      // Combinational out_ready -> in_ready path; accounted for in timing closure.
      assign bus.in_ready = (~main_valid | bus.out_ready) & ~hold & ~flush & rst_n;
    end
  endgenerate

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = main_valid & bus.out_ready & ~hold & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    main_d    = bus.in;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nx  = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept && HAS_SKID) begin
            state_nx  = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so the only move is skid -> main on a pop.
          if (pop) begin
            state_nx  = ONE;
            load_main = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  pipe_data_reg #(.N(N)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .en    (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  generate
    if (HAS_SKID) begin : g_skid
      pipe_data_reg #(.N(N)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (load_skid),
        .d     (bus.in),
        .q     (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

  assign bus.out_valid = main_valid;
  assign bus.out       = main_q;
  assign count         = occupancy(state);
  assign dbg_state     = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: SKID=1 and SKID=0 instances share one stimulus
// stream; each has a FIFO reference model that predicts every output.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic hold = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid_d = 1'b0;
  logic [W-1:0] in_d = '0;
  logic         out_ready_d = 1'b0;

  pipe_stage_skid_if #(.N(W)) if1 ();
  pipe_stage_skid_if #(.N(W)) if0 ();

  assign if1.in_valid  = in_valid_d;
  assign if1.in        = in_d;
  assign if1.out_ready = out_ready_d;
  assign if0.in_valid  = in_valid_d;
  assign if0.in        = in_d;
  assign if0.out_ready = out_ready_d;

  logic [OCC_W-1:0] count1, count0;
  state_t           st1, st0;

  pipe_stage_skid #(.N(W), .SKID(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .hold      (hold),
    .bus       (if1.slave),
    .count     (count1),
    .dbg_state (st1)
  );

  pipe_stage_skid #(.N(W), .SKID(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .hold      (hold),
    .bus       (if0.slave),
    .count     (count0),
    .dbg_state (st0)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // scoreboard: expected queues and the value out should currently show
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] last1 = '0;
  logic [W-1:0] last0 = '0;

  task automatic mon(input string nm, input bit skid, input logic rdy,
                     input logic ov, input logic [W-1:0] o,
                     input logic [OCC_W-1:0] cnt,
                     ref logic [W-1:0] q[$], ref logic [W-1:0] last);
    int   sz;
    logic mr;
    sz = q.size();
    mr = !hold && !flush && (skid ? (sz < 2) : (sz == 0 || out_ready_d));
    chk({nm, "_count"}, int'(cnt), sz);
    chk({nm, "_out_valid"}, int'(ov), int'(sz != 0));
    chk({nm, "_out"}, int'(o), int'(last));
    chk({nm, "_in_ready"}, int'(rdy), int'(mr));
    if (flush) begin
      q.delete();
      last = '0;
    end else if (!hold) begin
      if (out_ready_d && sz > 0) void'(q.pop_front());
      if (in_valid_d && mr) q.push_back(in_d);
    end
    if (q.size() > 0) last = q[0];
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q1.delete();
      exp_q0.delete();
      last1 = '0;
      last0 = '0;
    end else begin
      mon("s1", 1'b1, if1.in_ready, if1.out_valid, if1.out, count1, exp_q1, last1);
      mon("s0", 1'b0, if0.in_ready, if0.out_valid, if0.out, count0, exp_q0, last0);
    end
  end

  // driver: present inputs for one cycle, return 1 time unit after the edge
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy,
                     input logic h, input logic f);
    in_valid_d  = v;
    in_d        = d;
    out_ready_d = ordy;
    hold        = h;
    flush       = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out1", int'(if1.out), 0);
    chk("rst_cnt1", int'(count1), 0);

    // stream at full rate
    cyc(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    chk("stream_out_11", int'(if1.out), 'h11);
    cyc(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    chk("stream_out_22", int'(if1.out), 'h22);
    chk("stream_cnt", int'(count1), 1);
    cyc(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    chk("stream_out_33", int'(if1.out), 'h33);
    chk("stream_out0_33", int'(if0.out), 'h33);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // back-pressure into the skid entry
    cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    chk("bp_cnt_full", int'(count1), 2);
    in_valid_d = 1'b1;
    in_d       = 8'hA3;
    #1 chk("bp_in_ready_low", int'(if1.in_ready), 0);
    chk("bp_s0_ready_low", int'(if0.in_ready), 0);
    @(posedge clk);
    #1;
    cyc(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
    chk("bp_out_a2", int'(if1.out), 'hA2);
    chk("bp_ready_back", int'(if1.in_ready), 1);
    cyc(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
    chk("bp_out_a3", int'(if1.out), 'hA3);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // hazard hold
    cyc(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0);
    in_valid_d  = 1'b1;
    in_d        = 8'h99;
    out_ready_d = 1'b1;
    hold        = 1'b1;
    repeat (3) begin
      #1 chk("hold_in_ready", int'(if1.in_ready), 0);
      @(posedge clk);
      #1;
      chk("hold_out", int'(if1.out), 'h5C);
      chk("hold_cnt", int'(count1), 1);
      chk("hold_out_valid", int'(if1.out_valid), 1);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // flush from FULL
    cyc(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hB3, 1'b0, 1'b0, 1'b1);
    chk("flush_cnt", int'(count1), 0);
    chk("flush_out", int'(if1.out), 0);
    chk("flush_out_valid", int'(if1.out_valid), 0);
    chk("flush_out0", int'(if0.out), 0);

    // SKID=0 combinational ready
    cyc(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0);
    in_valid_d  = 1'b1;
    in_d        = 8'h77;
    out_ready_d = 1'b0;
    #1 chk("s0_ready_blocked", int'(if0.in_ready), 0);
    out_ready_d = 1'b1;
    #1 chk("s0_ready_flow", int'(if0.in_ready), 1);
    @(posedge clk);
    #1;
    chk("s0_out_77", int'(if0.out), 'h77);
    chk("s0_cnt", int'(count0), 1);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // asynchronous reset while FULL
    cyc(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hD2, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_full", int'(count1), 2);
    in_valid_d = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out", int'(if1.out), 0);
    chk("arst_out_valid", int'(if1.out_valid), 0);
    chk("arst_cnt", int'(count1), 0);
    chk("arst_in_ready", int'(if1.in_ready), 0);
    chk("arst_s0_in_ready", int'(if0.in_ready), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rel_in_ready", int'(if1.in_ready), 1);
    @(posedge clk);
    #1;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 9) < 7), W'($urandom), 1'($urandom_range(0, 9) < 6),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0));
    end
    repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register for the MIPS datapath: it is the valid/ready successor to the plain clear/hold stage registers. It carries an N-bit stage bundle (IF/ID, ID/EX, EX/MEM, MEM/WB) with a synchronous flush, a hazard-unit hold, and an optional second skid entry. The skid entry lets a stalled downstream stage back-pressure upstream without a combinational ready path. It sits between two pipeline stages and is controlled by the hazard/branch unit.

## Interface
- N, default 32: width of the stage bundle in bits.
- SKID, default 1: 1 gives a two-entry skid buffer with registered ready; 0 gives a single entry whose ready depends combinationally on out_ready.
- clk  input  1  pipeline clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- flush  input  1  synchronous clear (branch/exception squash); highest synchronous priority.
- hold  input  1  hazard stall; freezes all transfers this cycle.
- in_valid  input  1  upstream has a bundle.
- in_ready  output  1  stage can accept this cycle.
- in  input  N  upstream bundle.
- out_valid  output  1  out holds a valid bundle.
- out_ready  input  1  downstream accepts this cycle.
- out  output  N  head bundle (main entry).
- count  output  2  occupancy: 0, 1 or 2; 2 only when SKID=1.

## Operation
- Definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready & ~hold & ~flush.
- States: EMPTY (count 0), ONE (main entry valid), FULL (main and skid entries valid; SKID=1 only).
- in_ready:
  - SKID=1: ~skid_valid & ~hold & ~flush & rst_n.
  - SKID=0: (~main_valid | out_ready) & ~hold & ~flush & rst_n.
- Transitions:
  - EMPTY: accept → ONE, main ← in.
  - ONE, accept & pop → ONE, main ← in.
  - ONE, accept & ~pop → FULL, skid ← in (SKID=1 only; unreachable for SKID=0).
  - ONE, ~accept & pop → EMPTY.
  - ONE, neither → stay.
  - FULL: pop → ONE, main ← skid. in_ready is 0, so no accept occurs.
- Flush: next edge goes to EMPTY; main and skid data become 0, count becomes 0. The in bundle is not captured. out_ready is ignored.
- Hold: no accept and no pop; state and data unchanged. out_valid and out stay visible.
- Ordering: strict FIFO; bundles are never dropped or duplicated except by flush or reset.
- A pop to EMPTY leaves out at its last value, with out_valid=0.
- Priority: rst_n > flush > hold > normal handshake.

## Timing
- Reset (rst_n low, asynchronous): out=0, out_valid=0, count=0, skid cleared, in_ready=0. In the first cycle after release, in_ready=1 when hold and flush are low.
- Latency: a bundle accepted in EMPTY appears on out with out_valid=1 one cycle later.
- Throughput: one bundle per cycle while out_ready=1, for both SKID settings.
- SKID=1: in_ready depends only on registered state plus hold/flush. There is no out_ready→in_ready path.
- SKID=0: out_ready→in_ready is a combinational path, documented for timing closure.
- Back-pressure recovery (SKID=1): after out_ready rises in FULL, in_ready returns one cycle later.
- Reset asserted mid-operation, including FULL: contents are lost and the bench must not expect them.

## Structure
- Shared package pipe_pkg holds:
  - the state enum: EMPTY=2'd0, ONE=2'd1, FULL=2'd2;
  - the occupancy width constant (2).
- One natural sub-module: pipe_data_reg, an N-bit register with async active-low reset, sync clear and load enable. It is instantiated for the main entry and, under a generate on SKID, for the skid entry.
- The control FSM and count live in pipe_stage_skid.

## Test plan
- Reset with SKID=1, N=8, in FULL, rst_n dropped mid-cycle → out=0, out_valid=0, count=0, in_ready=0 immediately; in_ready=1 the cycle after release.
- Stream: push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1 → out shows 0x11, 0x22, 0x33 on cycles 1, 2, 3 after the first push; count stays 1.
- Back-pressure: out_ready=0, push 0xA1 then 0xA2 → count=2, in_ready=0, 0xA3 held upstream. Raise out_ready → out shows A1, A2, A3 in order with no loss.
- Hold: state ONE (0x5C), hold=1 for 3 cycles with in_valid=1 and out_ready=1 → in_ready=0, out=0x5C, count=1 throughout, no pop.
- Flush: FULL with in_valid=1, flush=1 for one cycle → next cycle count=0, out=0, out_valid=0, input not taken.
- SKID=0:
  - ONE with out_ready=0 → in_ready=0.
  - Same cycle out_ready=1 and push 0x77 → in_ready=1, out=0x77 next cycle, count=1.
